local_max_mesh: RTL

LOCAL_MAX_MESH -- requirements
Module: local_max_mesh

---
 rtl/local_max_mesh.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/local_max_mesh.sv
// local_max_mesh
//   Finds local maxima in a small image held in a register frame store.
//   Rows are loaded one at a time while idle. A scan evaluates one row per
//   cycle and emits a per-column flag that is set when no neighbour pixel
//   is strictly greater. The neighbourhood is 4- or 8-connected. Frame edges
//   either wrap (TORUS=1) or drop neighbours that fall outside (TORUS=0).
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   load_valid/row/data  row write into the frame store (accepted in IDLE only)
//   start, conn8         begin a scan; conn8 is latched when start is accepted
//   busy                 scan in progress (SCAN and DONE states)
//   out_valid/row/mask   registered result for one row
//   done                 one-cycle pulse at the end of a scan
//   count                total set mask bits of the last completed scan
module local_max_mesh #(
  parameter int W     = 26,
  parameter int H     = 18,
  parameter int BITS  = 2,
  parameter int TORUS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  input  logic [$clog2(H)-1:0]         load_row,
  input  logic [W*BITS-1:0]            load_data,
  input  logic                         start,
  input  logic                         conn8,
  output logic                         busy,
  output logic                         out_valid,
  output logic [$clog2(H)-1:0]         out_row,
  output logic [W-1:0]                 out_mask,
  output logic                         done,
  output logic [$clog2(W*H+1)-1:0]     count
);

  localparam int RW  = $clog2(H);
  localparam int RCW = $clog2(H+1);   // row counter also reaches H (drain step)
  localparam int CW  = $clog2(W*H+1);
  localparam int PW  = $clog2(W+1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [RCW-1:0]       row_q, row_d;
  logic                 conn8_q, conn8_d;
  logic                 out_valid_q, out_valid_d;
  logic [RW-1:0]        out_row_q, out_row_d;
  logic [W-1:0]         out_mask_q, out_mask_d;
  logic [CW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [W*BITS-1:0]    frame_q [H];
  logic [W*BITS-1:0]    frame_d [H];

  logic [W-1:0]         mask;
  logic [PW-1:0]        pop;

  function automatic logic [BITS-1:0] pix(input logic [W*BITS-1:0] vec, input int col);
    return vec[col*BITS +: BITS];
  endfunction

  // Neighbourhood evaluation for the row addressed by row_q. The drain
  // step (row_q == H) evaluates row 0 harmlessly; its result is discarded.
  always_comb begin : mask_eval
    int                rc, ru, rd, cl, cr;
    logic              up_ok, dn_ok, l_ok, r_ok, keep;
    logic [BITS-1:0]   ctr;
    logic [W*BITS-1:0] row_u, row_c, row_d_v;
    // NOTE: every variable in a combinational block gets a value on every
    // path before it is read; otherwise a latch is inferred.
    mask  = '0;
    cl    = 0;
    cr    = 0;
    l_ok  = 1'b1;
    r_ok  = 1'b1;
    keep  = 1'b1;
    ctr   = '0;
    up_ok = 1'b1;
    dn_ok = 1'b1;
    rc    = (int'(row_q) < H) ? int'(row_q) : 0;
    ru    = rc - 1;
    rd    = rc + 1;
    if (ru < 0) begin
      if (TORUS != 0) ru = H - 1;
      else begin ru = 0; up_ok = 1'b0; end
    end
    if (rd >= H) begin
      rd = 0;
      if (TORUS == 0) dn_ok = 1'b0;
    end
    row_u   = frame_q[ru[RW-1:0]];
    row_c   = frame_q[rc[RW-1:0]];
    row_d_v = frame_q[rd[RW-1:0]];
    for (int c = 0; c < W; c++) begin
      cl   = c - 1;
      cr   = c + 1;
      l_ok = 1'b1;
      r_ok = 1'b1;
      if (cl < 0) begin
        if (TORUS != 0) cl = W - 1;
        else begin cl = 0; l_ok = 1'b0; end
      end
      if (cr >= W) begin
        cr = 0;
        if (TORUS == 0) r_ok = 1'b0;
      end
      ctr  = pix(row_c, c);
      keep = 1'b1;
      // Only a strictly greater neighbour clears the flag; ties keep it.
      if (up_ok && pix(row_u, c)   > ctr) keep = 1'b0;
      if (dn_ok && pix(row_d_v, c) > ctr) keep = 1'b0;
      if (l_ok  && pix(row_c, cl)  > ctr) keep = 1'b0;
      if (r_ok  && pix(row_c, cr)  > ctr) keep = 1'b0;
      if (conn8_q) begin
        if (up_ok && l_ok && pix(row_u, cl)   > ctr) keep = 1'b0;
        if (up_ok && r_ok && pix(row_u, cr)   > ctr) keep = 1'b0;
        if (dn_ok && l_ok && pix(row_d_v, cl) > ctr) keep = 1'b0;
        if (dn_ok && r_ok && pix(row_d_v, cr) > ctr) keep = 1'b0;
      end
      mask[c] = keep;
    end
  end

  always_comb begin : popcount
    pop = '0;
    for (int c = 0; c < W; c++) pop = pop + PW'(mask[c]);
  end

  always_comb begin : next_state
    state_d     = state_q;
    row_d       = row_q;
    conn8_d     = conn8_q;
    out_valid_d = 1'b0;
    out_row_d   = out_row_q;
    out_mask_d  = out_mask_q;
    acc_d       = acc_q;
    count_d     = count_q;
    for (int r = 0; r < H; r++) frame_d[r] = frame_q[r];

    unique case (state_q)
      S_IDLE: begin
        if (load_valid && (int'(load_row) < H)) frame_d[load_row] = load_data;
        if (start) begin
          state_d = S_SCAN;
          row_d   = '0;
          acc_d   = '0;
          conn8_d = conn8;
        end
      end
      S_SCAN: begin
        if (row_q < RCW'(H)) begin
          out_valid_d = 1'b1;
          out_row_d   = row_q[RW-1:0];
          out_mask_d  = mask;
          acc_d       = acc_q + CW'(pop);
          row_d       = row_q + RCW'(1);
        end else begin
          // Last row already registered; publish the total with done.
          state_d = S_DONE;
          count_d = acc_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      conn8_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_mask_q  <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      // NOTE: the frame store is plain flops that must read as zero after
      // reset, so it is reset like any other register (not an inferred RAM).
      for (int r = 0; r < H; r++) frame_q[r] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      row_q       <= row_d;
      conn8_q     <= conn8_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_mask_q  <= out_mask_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      for (int r = 0; r < H; r++) frame_q[r] <= frame_d[r];
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_mask  = out_mask_q;
  assign count     = count_q;

endmodule
